// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory controller.
// The future instruction cache reuses these.
package imem_pkg;

   // Fetch FSM state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } imem_state_t;

   // Default geometry and timing of the instruction memory
   localparam int IMEM_ADDR_WIDTH   = 32;
   localparam int IMEM_DEPTH_BYTES  = 1024;
   localparam int IMEM_INSTR_BYTES  = 4;
   localparam int IMEM_READ_LATENCY = 4;

endpackage

// File: rtl/imem_array.sv
// Byte-wide instruction storage.
// It has one byte write port for program loading and a combinational
// little-endian word read from a base byte address.
module imem_array
   import imem_pkg::*;
#(
   parameter int DEPTH_BYTES = IMEM_DEPTH_BYTES,
   parameter int INSTR_BYTES = IMEM_INSTR_BYTES,
   localparam int AW = $clog2(DEPTH_BYTES)
)(
   input  logic                     clk,
   input  logic                     load_en,
   input  logic [AW-1:0]            load_addr,
   input  logic [7:0]               load_data,
   input  logic [AW-1:0]            rd_addr,
   output logic [8*INSTR_BYTES-1:0] rd_word
);

   logic [7:0] mem [DEPTH_BYTES];

   // Program loading writes one byte per edge.
   // Reset does not clear the memory.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   // Assemble the word with the lowest address in the least significant byte
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < INSTR_BYTES; k++) begin
         rd_word[8*k +: 8] = mem[rd_addr + AW'(k)];
      end
   end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller.
// It accepts a fetch, stalls the CPU for a fixed number of cycles, then
// presents the instruction word for one DONE cycle.
module instr_mem_ctrl
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH   = IMEM_ADDR_WIDTH,
   parameter int DEPTH_BYTES  = IMEM_DEPTH_BYTES,
   parameter int INSTR_BYTES  = IMEM_INSTR_BYTES,
   parameter int READ_LATENCY = IMEM_READ_LATENCY,
   localparam int AW = $clog2(DEPTH_BYTES)
)(
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     READ,
   input  logic [ADDR_WIDTH-1:0]    ADDRESS,
   output logic [8*INSTR_BYTES-1:0] READDATA,
   output logic                     BUSYWAIT,
   output logic                     ADDR_ERR,
   input  logic                     LOAD_EN,
   input  logic [AW-1:0]            LOAD_ADDR,
   input  logic [7:0]               LOAD_DATA
);

   localparam int                    CW         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CW-1:0]         COUNT_INIT = CW'(READ_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

   imem_state_t             state;
   imem_state_t             state_next;
   logic [CW-1:0]           count;
   logic [ADDR_WIDTH-1:0]   fetch_addr;
   logic [8*INSTR_BYTES-1:0] array_word;
   logic                    in_range;

   imem_array #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_array (
      .clk       (CLK),
      .load_en   (LOAD_EN),
      .load_addr (LOAD_ADDR),
      .load_data (LOAD_DATA),
      .rd_addr   (fetch_addr[AW-1:0]),
      .rd_word   (array_word)
   );

   // An address is in range only if no bit above the array index is set
   assign in_range = ((fetch_addr >> AW) == '0);

   // State register.
   // Reset drops any fetch in progress without producing a DONE cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the stall output.
   // During reset the stall behaves as it does in IDLE.
   always_comb begin
      state_next = state;
      BUSYWAIT   = 1'b0;
      case (state)
         IDLE: begin
            BUSYWAIT = READ;
            if (READ) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            BUSYWAIT = 1'b1;
            if (count == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (RESET) begin
         BUSYWAIT = READ;
      end
   end

   // Fetch datapath.
   // - The aligned address is latched when a request is accepted.
   // - The counter runs down while BUSY.
   // - The word is captured on the way into DONE. A load on that same edge
   //   is not yet visible.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         count      <= '0;
         fetch_addr <= '0;
         READDATA   <= '0;
         ADDR_ERR   <= 1'b0;
      end else begin
         ADDR_ERR <= 1'b0;
         case (state)
            IDLE: begin
               if (READ) begin
                  fetch_addr <= ADDRESS & ALIGN_MASK;
                  count      <= COUNT_INIT;
               end
            end
            BUSY: begin
               if (count == '0) begin
                  READDATA <= in_range ? array_word : '0;
                  ADDR_ERR <= ~in_range;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl.
// The main instance uses default parameters; a small instance uses a
// one-cycle latency and a 64-byte array.
module tb_instr_mem_ctrl;

   localparam int L       = 4;
   localparam int DEPTH   = 1024;
   localparam int IB      = 4;
   localparam int S_DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        read;
   logic [31:0] address;
   logic [31:0] readdata;
   logic        busywait;
   logic        addr_err;
   logic        load_en;
   logic [9:0]  load_addr;
   logic [7:0]  load_data;

   logic        s_read;
   logic [31:0] s_address;
   logic [31:0] s_readdata;
   logic        s_busywait;
   logic        s_addr_err;
   logic        s_load_en;
   logic [5:0]  s_load_addr;
   logic [7:0]  s_load_data;

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0] modelMem [DEPTH];
   logic [7:0] smallMem [S_DEPTH];

   always #5 clk = ~clk;

   instr_mem_ctrl u_dut (
      .CLK       (clk),
      .RESET     (reset),
      .READ      (read),
      .ADDRESS   (address),
      .READDATA  (readdata),
      .BUSYWAIT  (busywait),
      .ADDR_ERR  (addr_err),
      .LOAD_EN   (load_en),
      .LOAD_ADDR (load_addr),
      .LOAD_DATA (load_data)
   );

   instr_mem_ctrl #(
      .ADDR_WIDTH   (32),
      .DEPTH_BYTES  (S_DEPTH),
      .INSTR_BYTES  (4),
      .READ_LATENCY (1)
   ) u_dut_small (
      .CLK       (clk),
      .RESET     (reset),
      .READ      (s_read),
      .ADDRESS   (s_address),
      .READDATA  (s_readdata),
      .BUSYWAIT  (s_busywait),
      .ADDR_ERR  (s_addr_err),
      .LOAD_EN   (s_load_en),
      .LOAD_ADDR (s_load_addr),
      .LOAD_DATA (s_load_data)
   );

   // Reference: the aligned word from the model memory, or 0 when out of range
   function automatic logic [31:0] expectWord(input logic [31:0] addr);
      logic [31:0] base;
      logic [31:0] w;
      base = addr - (addr % IB);
      w = '0;
      if (base < DEPTH) begin
         for (int k = 0; k < IB; k++) begin
            w = w | (32'(modelMem[base + k]) << (8 * k));
         end
      end
      return w;
   endfunction

   function automatic logic expectErr(input logic [31:0] addr);
      return (addr - (addr % IB)) >= DEPTH;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Writes one byte to both instances.
   // The small array only receives bytes inside its range.
   task automatic loadByte(input int a, input logic [7:0] d);
      load_en   = 1'b1;
      load_addr = 10'(a);
      load_data = d;
      if (a < S_DEPTH) begin
         s_load_en   = 1'b1;
         s_load_addr = 6'(a);
         s_load_data = d;
         smallMem[a] = d;
      end
      @(negedge clk);
      load_en   = 1'b0;
      s_load_en = 1'b0;
      modelMem[a] = d;
   endtask

   // One fetch on the main instance, started from IDLE.
   // It counts stalled edges and checks the DONE cycle. It then checks that
   // READDATA holds and ADDR_ERR clears once the FSM returns to IDLE.
   task automatic applyStimulus(input logic [31:0] addr, input bit dropRead, input bit loadAtCapture,
                                input int loadA, input logic [7:0] loadD, input bit holdRead,
                                input logic [31:0] nextAddr, input string tag);
      logic [31:0] exp;
      logic        expE;
      int          highCount;
      exp  = expectWord(addr);
      expE = expectErr(addr);
      read    = 1'b1;
      address = addr;
      #1;
      highCount = 0;
      while (busywait === 1'b1 && highCount < 50) begin
         highCount++;
         if (loadAtCapture && highCount == L + 1) begin
            load_en   = 1'b1;
            load_addr = 10'(loadA);
            load_data = loadD;
         end
         @(negedge clk);
         load_en = 1'b0;
         address = $urandom;
         if (dropRead) read = 1'b0;
         #1;
      end
      checkOutput({tag, "_latency"}, 64'(highCount), 64'(L + 1));
      checkOutput({tag, "_data"}, 64'(readdata), 64'(exp));
      checkOutput({tag, "_err"}, 64'(addr_err), 64'(expE));
      if (loadAtCapture) modelMem[loadA] = loadD;
      read    = holdRead;
      address = nextAddr;
      @(negedge clk);
      #1;
      checkOutput({tag, "_hold"}, 64'(readdata), 64'(exp));
      checkOutput({tag, "_errclr"}, 64'(addr_err), 64'd0);
      checkOutput({tag, "_idlebw"}, 64'(busywait), 64'(holdRead));
   endtask

   // One fetch on the small instance (latency 1, 64 bytes)
   task automatic smallFetch(input logic [31:0] addr, input string tag);
      logic [31:0] base;
      logic [31:0] exp;
      int          highCount;
      base = addr - (addr % 4);
      exp  = '0;
      if (base < S_DEPTH) begin
         for (int k = 0; k < 4; k++) exp = exp | (32'(smallMem[base + k]) << (8 * k));
      end
      s_read    = 1'b1;
      s_address = addr;
      #1;
      highCount = 0;
      while (s_busywait === 1'b1 && highCount < 50) begin
         highCount++;
         @(negedge clk);
         s_read = 1'b0;
         #1;
      end
      checkOutput({tag, "_latency"}, 64'(highCount), 64'd2);
      checkOutput({tag, "_data"}, 64'(s_readdata), 64'(exp));
      checkOutput({tag, "_err"}, 64'(s_addr_err), 64'(base >= S_DEPTH));
      @(negedge clk);
      #1;
      checkOutput({tag, "_errclr"}, 64'(s_addr_err), 64'd0);
   endtask

   // Guards against a hung FSM
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: directed scenarios first, then randomized fetches
   initial begin
      logic [31:0] addrs [41];
      bit          hold;

      reset = 1'b1; read = 1'b0; address = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      s_read = 1'b0; s_address = '0;
      s_load_en = 1'b0; s_load_addr = '0; s_load_data = '0;

      // Fill the whole array while reset is held; these loads must still land
      for (int a = 0; a < DEPTH; a++) loadByte(a, 8'($urandom));
      reset = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("reset_data", 64'(readdata), 64'd0);
      checkOutput("reset_err", 64'(addr_err), 64'd0);
      checkOutput("reset_bw", 64'(busywait), 64'd0);

      // Directed word at address 0
      loadByte(0, 8'h05); loadByte(1, 8'h00); loadByte(2, 8'h04); loadByte(3, 8'h00);
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 32'h0, "word0");
      checkOutput("word0_const", 64'(readdata), 64'h00040005);

      // Back-to-back fetches with READ held
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 32'h4, "b2b0");
      applyStimulus(32'h4, 1'b0, 1'b0, 0, 8'h00, 1'b1, 32'h8, "b2b4");
      applyStimulus(32'h8, 1'b0, 1'b0, 0, 8'h00, 1'b0, 32'h0, "b2b8");

      // Unaligned out-of-range address
      applyStimulus(32'h406, 1'b0, 1'b0, 0, 8'h00, 1'b0, 32'h0, "oor406");
      checkOutput("oor406_const", 64'(readdata), 64'd0);

      // Load on the capture edge is not seen; the re-fetch sees it
      loadByte(8, 8'h11);
      applyStimulus(32'h8, 1'b0, 1'b1, 8, 8'hAA, 1'b0, 32'h0, "rbw_old");
      checkOutput("rbw_old_byte", 64'(readdata[7:0]), 64'h11);
      applyStimulus(32'h8, 1'b0, 1'b0, 0, 8'h00, 1'b0, 32'h0, "rbw_new");
      checkOutput("rbw_new_byte", 64'(readdata[7:0]), 64'hAA);

      // Reset in the second BUSY cycle, with a load during reset
      read = 1'b1; address = 32'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1; read = 1'b0;
      load_en = 1'b1; load_addr = 10'd1; load_data = 8'h5A;
      #1;
      checkOutput("rst_bw_noread", 64'(busywait), 64'd0);
      read = 1'b1;
      #1;
      checkOutput("rst_bw_read", 64'(busywait), 64'd1);
      @(negedge clk);
      reset = 1'b0; read = 1'b0; load_en = 1'b0;
      modelMem[1] = 8'h5A;
      #1;
      checkOutput("rst_abort_data", 64'(readdata), 64'd0);
      checkOutput("rst_abort_err", 64'(addr_err), 64'd0);
      for (int i = 0; i < L + 2; i++) begin
         checkOutput("rst_no_done_bw", 64'(busywait), 64'd0);
         checkOutput("rst_no_done_err", 64'(addr_err), 64'd0);
         @(negedge clk);
         #1;
      end
      applyStimulus(32'h0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 32'h0, "after_rst");

      // Randomized fetches, loads, dropped and held requests
      for (int i = 0; i < 41; i++) begin
         case ($urandom_range(0, 9))
            0:       addrs[i] = $urandom;
            1, 2:    addrs[i] = $urandom_range(DEPTH, 2 * DEPTH - 1);
            default: addrs[i] = $urandom_range(0, DEPTH - 1);
         endcase
      end
      for (int i = 0; i < 40; i++) begin
         hold = ($urandom_range(0, 2) == 0);
         applyStimulus(addrs[i], ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, DEPTH - 1), 8'($urandom), hold, addrs[i + 1], "rand");
         if (!hold) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
               loadByte($urandom_range(0, DEPTH - 1), 8'($urandom));
            end
         end
      end
      read = 1'b0;
      @(negedge clk);
      #1;

      // Short-latency, small-array instance
      smallFetch(32'd0, "small0");
      smallFetch(32'd62, "small62");
      smallFetch(32'd64, "small64");
      checkOutput("small64_zero", 64'(s_readdata), 64'd0);
      smallFetch(32'd66, "small66");

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
